// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle RISC-V style main control FSM (JAL state under `MULTI_CYCLE_CONTROL_JAL_EN)
module multi_cycle_control (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [1:0] o_alu_ctl,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
`endif
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       illegal_op;

  assign o_state = state;

  // State register; reset wins from any state, including a pending memory access
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state decode; unknown opcodes in DECODE are flagged and abandoned
  always_comb begin
    next_state = S_FETCH;
    illegal_op = 1'b0;
    case (state)
      S_FETCH:    next_state = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_I:         next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
          OP_JAL:       next_state = S_JAL;
`endif
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:   next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
      S_JAL:      next_state = S_ALUWB;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode; during reset show FETCH datapath selects with all enables off
  always_comb begin
    o_alu_ctl    = 2'b00;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_result_src = 2'b00;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_write  = 1'b0;
    o_illegal    = 1'b0;
    if (i_rst) begin
      o_alu_src_b  = 2'b10;
      o_result_src = 2'b10;
    end else begin
      case (state)
        S_FETCH: begin
          o_alu_src_b  = 2'b10;
          o_result_src = 2'b10;
          o_ir_write   = i_mem_ready;
          o_pc_write   = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b01;
          o_illegal   = illegal_op;
        end
        S_MEMADR: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
        end
        S_MEMREAD: o_adr_src = 1'b1;
        S_MEMWB: begin
          o_result_src = 2'b01;
          o_reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          o_adr_src   = 1'b1;
          o_mem_write = 1'b1;
        end
        S_EXECUTER: begin
          o_alu_src_a = 2'b10;
          o_alu_ctl   = 2'b10;
        end
        S_EXECUTEI: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
          o_alu_ctl   = 2'b10;
        end
        S_ALUWB: o_reg_write = 1'b1;
        S_BEQ: begin
          o_alu_src_a = 2'b10;
          o_alu_ctl   = 2'b01;
          o_pc_write  = i_zero;
        end
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
        S_JAL: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b10;
          o_pc_write  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - directed table, corner sequences and randomized model check for multi_cycle_control
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       rdy;
  logic [1:0] alu_ctl, src_a, src_b, result_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal;
  logic [3:0] state;

  multi_cycle_control dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(rdy),
    .o_alu_ctl(alu_ctl), .o_alu_src_a(src_a), .o_alu_src_b(src_b),
    .o_result_src(result_src), .o_adr_src(adr_src), .o_ir_write(ir_write),
    .o_pc_write(pc_write), .o_reg_write(reg_write), .o_mem_write(mem_write),
    .o_illegal(illegal), .o_state(state)
  );

  always #5 clk = ~clk;

  // {alu_ctl, src_a, src_b, result_src, adr_src, ir, pc, reg, mem, illegal}
  logic [13:0] outs;
  assign outs = {alu_ctl, src_a, src_b, result_src, adr_src,
                 ir_write, pc_write, reg_write, mem_write, illegal};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         BAD = 7'b1111111;

  localparam logic [13:0] O_FETCH   = 14'b00_00_10_10_0_00000;
  localparam logic [13:0] O_FETCH_R = 14'b00_00_10_10_0_11000;
  localparam logic [13:0] O_RST     = 14'b00_00_10_10_0_00000;
  localparam logic [13:0] O_DEC     = 14'b00_01_01_00_0_00000;
  localparam logic [13:0] O_DEC_ILL = 14'b00_01_01_00_0_00001;
  localparam logic [13:0] O_MADR    = 14'b00_10_01_00_0_00000;
  localparam logic [13:0] O_MRD     = 14'b00_00_00_00_1_00000;
  localparam logic [13:0] O_MWB     = 14'b00_00_00_01_0_00100;
  localparam logic [13:0] O_MWR     = 14'b00_00_00_00_1_00010;
  localparam logic [13:0] O_EXR     = 14'b10_10_00_00_0_00000;
  localparam logic [13:0] O_ALUWB   = 14'b00_00_00_00_0_00100;
  localparam logic [13:0] O_EXI     = 14'b10_10_01_00_0_00000;
  localparam logic [13:0] O_BEQ_NZ  = 14'b01_10_00_00_0_00000;
  localparam logic [13:0] O_BEQ_Z   = 14'b01_10_00_00_0_01000;
  localparam logic [13:0] O_JAL     = 14'b00_01_10_00_0_01000;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] outs;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_st;
  int   q[$];

  task automatic add(input logic r, input logic [6:0] o, input logic z, input logic rd,
                     input logic [3:0] s, input logic [13:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.st = s; v.outs = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs mid-period and check the Moore outputs before the next edge
  task automatic step(input logic r, input logic [6:0] o, input logic z, input logic rd,
                      input logic [3:0] s, input logic [13:0] e, input string tag);
    @(negedge clk);
    rst = r; op = o; zero = z; rdy = rd;
    #1;
    check({tag, ".state"}, {10'd0, state}, {10'd0, s});
    check({tag, ".outs"}, outs, e);
  endtask

  function automatic logic legal(input logic [6:0] o);
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
    return (o inside {LW, SW, RT, IT, BQ, JL});
`else
    return (o inside {LW, SW, RT, IT, BQ});
`endif
  endfunction

  // Expected outputs from the per-state control table plus the input-dependent bits
  function automatic logic [13:0] spec_outs(input int s, input logic r, input logic rd,
                                            input logic z, input logic [6:0] o);
    logic [13:0] base [16];
    logic [13:0] x;
    foreach (base[i]) base[i] = 14'd0;
    base[0] = O_FETCH;  base[1] = O_DEC;   base[2] = O_MADR;  base[3] = O_MRD;
    base[4] = O_MWB;    base[5] = O_MWR;   base[6] = O_EXR;   base[7] = O_ALUWB;
    base[8] = O_EXI;    base[10] = O_BEQ_NZ;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
    base[9] = O_JAL;
`endif
    if (r) return O_RST;
    x = base[s];
    if (s == 0)  begin x[4] = rd; x[3] = rd; end
    if (s == 1)  x[0] = !legal(o);
    if (s == 10) x[3] = z;
    return x;
  endfunction

  initial begin
    rst = 1'b1; op = 7'd0; zero = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);

    // reset holds enables low even with ready high; then wait-for-ready fetch
    add(1, 0, 0, 1, 0, O_RST);
    add(0, 0, 0, 0, 0, O_FETCH);
    add(0, 0, 0, 0, 0, O_FETCH);
    add(0, 0, 0, 0, 0, O_FETCH);
    add(0, 0, 0, 1, 0, O_FETCH_R);
    // lw: 1,2,3,4 then back to fetch
    add(0, LW, 0, 1, 1, O_DEC);
    add(0, LW, 0, 1, 2, O_MADR);
    add(0, LW, 0, 1, 3, O_MRD);
    add(0, LW, 0, 1, 4, O_MWB);
    add(0, LW, 0, 1, 0, O_FETCH_R);
    // beq taken then not taken
    add(0, BQ, 1, 1, 1, O_DEC);
    add(0, BQ, 1, 1, 10, O_BEQ_Z);
    add(0, BQ, 0, 1, 0, O_FETCH_R);
    add(0, BQ, 0, 1, 1, O_DEC);
    add(0, BQ, 0, 1, 10, O_BEQ_NZ);
    add(0, BQ, 0, 1, 0, O_FETCH_R);
    // illegal opcode
    add(0, BAD, 0, 1, 1, O_DEC_ILL);
    add(0, BAD, 0, 1, 0, O_FETCH_R);
    // R-type and I-type
    add(0, RT, 0, 1, 1, O_DEC);
    add(0, RT, 0, 1, 6, O_EXR);
    add(0, RT, 0, 1, 7, O_ALUWB);
    add(0, IT, 0, 1, 0, O_FETCH_R);
    add(0, IT, 0, 1, 1, O_DEC);
    add(0, IT, 0, 1, 8, O_EXI);
    add(0, IT, 0, 1, 7, O_ALUWB);
    add(0, LW, 0, 1, 0, O_FETCH_R);
    // lw with one memory wait cycle
    add(0, LW, 0, 1, 1, O_DEC);
    add(0, LW, 0, 1, 2, O_MADR);
    add(0, LW, 0, 0, 3, O_MRD);
    add(0, LW, 0, 1, 3, O_MRD);
    add(0, LW, 0, 1, 4, O_MWB);
    add(0, LW, 0, 0, 0, O_FETCH);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].rdy, tbl[i].st, tbl[i].outs,
           $sformatf("vec%0d", i));

    // sw with two wait cycles: mem_write for three cycles
    step(0, SW, 0, 1, 0, O_FETCH_R, "sw.f");
    step(0, SW, 0, 1, 1, O_DEC, "sw.d");
    step(0, SW, 0, 1, 2, O_MADR, "sw.a");
    step(0, SW, 0, 0, 5, O_MWR, "sw.w0");
    step(0, SW, 0, 0, 5, O_MWR, "sw.w1");
    step(0, SW, 0, 1, 5, O_MWR, "sw.w2");
    step(0, JL, 0, 1, 0, O_FETCH_R, "sw.end");

    // jal under the current build configuration
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
    step(0, JL, 0, 1, 1, O_DEC, "jal.d");
    step(0, JL, 0, 1, 9, O_JAL, "jal.j");
    step(0, JL, 0, 1, 7, O_ALUWB, "jal.wb");
    step(0, SW, 0, 1, 0, O_FETCH_R, "jal.end");
`else
    step(0, JL, 0, 1, 1, O_DEC_ILL, "jal.ill");
    step(0, SW, 0, 1, 0, O_FETCH_R, "jal.end");
`endif

    // reset while stalled in MEMWRITE
    step(0, SW, 0, 1, 1, O_DEC, "rsw.d");
    step(0, SW, 0, 1, 2, O_MADR, "rsw.a");
    step(0, SW, 0, 0, 5, O_MWR, "rsw.w");
    step(1, SW, 0, 0, 5, O_RST, "rsw.rst");
    step(0, SW, 0, 0, 0, O_FETCH, "rsw.after");

    // randomized run against the instruction-path model
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    m_st = 0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 63) == 0);
      rdy  = $urandom_range(0, 1);
      zero = $urandom_range(0, 1);
      if (m_st == 0) begin
        case ($urandom_range(0, 6))
          0: op = LW;  1: op = SW;  2: op = RT;  3: op = IT;
          4: op = BQ;  5: op = JL;  default: op = 7'($urandom);
        endcase
      end
      #1;
      check($sformatf("rnd%0d.state", c), {10'd0, state}, 14'(m_st));
      check($sformatf("rnd%0d.outs", c), outs, spec_outs(m_st, rst, rdy, zero, op));
      if (rst) begin
        m_st = 0;
        q.delete();
      end else if (m_st == 0) begin
        if (rdy) m_st = 1;
      end else if (m_st == 1) begin
        case (op)
          LW: q = '{2, 3, 4};
          SW: q = '{2, 5};
          RT: q = '{6, 7};
          IT: q = '{8, 7};
          BQ: q = '{10};
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
          JL: q = '{9, 7};
`endif
          default: q.delete();
        endcase
        m_st = (q.size() != 0) ? q.pop_front() : 0;
      end else if ((m_st == 3 || m_st == 5) && !rdy) begin
        m_st = m_st;
      end else begin
        m_st = (q.size() != 0) ? q.pop_front() : 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
